dlx_dmem_responder: RTL
=======================

# dlx_dmem_responder

Word-organised data-memory responder for the DLX pipeline's load/store port, with a request/acknowledge handshake and configurable wait states. It sits between the pipeline's memory stage (the initiator) and backing storage, serving LW/SW traffic. It exposes the same last-write observation outputs the bench already uses.

## Interface

- DEPTH, 64, number of 32-bit words stored; power of two, ≥4
- WAIT_CYCLES, 1, extra cycles inserted between request capture and acknowledge; 0..15
- clk_i  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state and memory
- req_i  input  1  request valid; held high by initiator until ack_o seen
- we_i  input  1  1 = store (SW), 0 = load (LW); sampled with req_i
- adr_i  input  32  byte address; word index = adr_i[log2(DEPTH)+1:2]
- data_i  input  32  store data; sampled with req_i
- data_o  output  32  load data; valid only while ack_o=1
- ack_o  output  1  one-cycle completion strobe
- err_o  output  1  qualifies ack_o: misaligned or out-of-range access
- mem_addr_in_use  output  32  byte address of last committed store
- mem_addr_in_use_value  output  32  data of last committed store

## Operation

- FSM states: IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: on req_i=1 capture we_i, adr_i, data_i. If WAIT_CYCLES=0 → RESP, else → WAIT with counter loaded to WAIT_CYCLES-1.
- WAIT: counter decrements each cycle; at 0 → RESP. req_i/adr_i/data_i changes ignored (captured copies used).
- RESP: ack_o=1 for exactly one cycle; → IDLE unconditionally.
- Error: adr_i[1:0]≠0 or adr_i ≥ 4·DEPTH → err_o=1 with ack_o, data_o=0, no write, observation outputs unchanged.
- Load: data_o = mem[index] read on entry to RESP (registered).
- Store: mem[index] ← captured data at the edge leaving RESP; same edge updates mem_addr_in_use/mem_addr_in_use_value. data_o=0 during store acks.
- Initiator contract: deassert req_i at the edge where it samples ack_o=1. req_i high in IDLE is always a new request.
- req_i=1 while in WAIT/RESP never starts a second transaction.
- Reset values: ack_o=0, err_o=0, data_o=0, mem_addr_in_use=0, mem_addr_in_use_value=0, all memory words 0, counter 0.
- Reset mid-transaction: return to IDLE immediately; pending store is discarded; no ack.

## Timing

- Request sampled at edge E (in IDLE) → ack_o high during the cycle after edge E+WAIT_CYCLES (WAIT_CYCLES=0: cycle after E; default: 2 cycles after sample).
- Minimum request-to-request spacing: WAIT_CYCLES+2 cycles.
- Read-after-write: a load issued after a store's ack returns the stored value (write commits before IDLE re-samples).
- Outputs are registered; no combinational path from req_i/adr_i to ack_o, err_o or data_o.

## Structure

- Shared package dlx_mem_pkg: state enumeration (IDLE/WAIT/RESP), WORD_BYTES=4, width constant for WAIT_CYCLES counter (4 bits).
- Sub-module dlx_dmem_array: DEPTH×32 storage, one synchronous write port, one registered read port, async clear on reset.
- FSM, counter, address check and observation registers live in the top module.

## Test plan

- Reset: assert reset mid-run → all outputs 0, read of adr 0x8 after release returns 0x00000000.
- Store/load, WAIT_CYCLES=1: SW adr 0x8 data 0x0000001E → ack 2 cycles after sample, mem_addr_in_use=0x8, value=0x1E; then LW 0x8 → data_o=0x0000001E with ack.
- Errors: LW adr 0x6 → ack+err_o, data_o=0; SW adr 0x100 with DEPTH=64 → ack+err_o, mem_addr_in_use unchanged.
- Zero wait: WAIT_CYCLES=0, back-to-back SW 0x4=0xA5A5A5A5, LW 0x4 → each ack 1 cycle after sample, spacing 2 cycles, load returns 0xA5A5A5A5.
- Held request: req_i held high through WAIT with adr_i changed to 0xC → exactly one ack, access uses originally captured address.
- Reset during WAIT of SW 0x10=0x55 → no ack; later LW 0x10 returns 0.

Source files
------------

// File: rtl/dlx_mem_pkg.sv
// Shared definitions for the DLX data-memory responder: FSM states, word size,
// wait-counter width and the access-legality check.
package dlx_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CNT_W      = 4;

  // Misaligned or beyond the last stored word.
  function automatic logic addr_err(input logic [31:0] adr, input int unsigned depth);
    return (adr[1:0] != 2'b00) || (adr >= 32'(WORD_BYTES * depth));
  endfunction

endpackage

// File: rtl/dlx_dmem_array.sv
// DEPTH x 32 word storage: one synchronous write port, one registered read port
// whose output returns to zero when not reading; cleared asynchronously on reset.
module dlx_dmem_array #(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_d, rdata_q;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (re_i) rdata_d = mem_q[raddr_i];
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dlx_dmem_responder.sv
// DLX load/store data-memory responder: req/ack handshake with WAIT_CYCLES wait
// states, error qualification and last-committed-store observation registers.
module dlx_dmem_responder
  import dlx_mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic [31:0] mem_addr_in_use,
  output logic [31:0] mem_addr_in_use_value
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [31:0]       obs_adr_q, obs_adr_d;
  logic [31:0]       obs_val_q, obs_val_d;

  logic [31:0]       eff_adr;
  logic              eff_we;
  logic              enter_resp;
  logic              rd_en;
  logic              commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    // With zero wait states the read happens on the capture edge, so the
    // access is described by the live inputs rather than the captured copies.
    eff_adr = adr_q;
    eff_we  = we_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          adr_d   = adr_i;
          wdata_d = data_i;
          eff_adr = adr_i;
          eff_we  = we_i;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    enter_resp = (state_d == RESP) && (state_q != RESP);
    ack_d      = enter_resp;
    err_d      = enter_resp && addr_err(eff_adr, DEPTH);
    rd_en      = enter_resp && !eff_we && !addr_err(eff_adr, DEPTH);

    commit     = (state_q == RESP) && we_q && !addr_err(adr_q, DEPTH);
    obs_adr_d  = commit ? adr_q   : obs_adr_q;
    obs_val_d  = commit ? wdata_q : obs_val_q;
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      wdata_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      obs_adr_q <= '0;
      obs_val_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      wdata_q   <= wdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      obs_adr_q <= obs_adr_d;
      obs_val_q <= obs_val_d;
    end
  end

  dlx_dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clk_i),
    .reset   (reset),
    .we_i    (commit),
    .waddr_i (adr_q[AW+1:2]),
    .wdata_i (wdata_q),
    .re_i    (rd_en),
    .raddr_i (eff_adr[AW+1:2]),
    .rdata_o (data_o)
  );

  assign ack_o                 = ack_q;
  assign err_o                 = err_q;
  assign mem_addr_in_use       = obs_adr_q;
  assign mem_addr_in_use_value = obs_val_q;

endmodule
